// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM state encodings
// and frame-format constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } uart_state_e;

  localparam int   DATA_BITS  = 8;
  // Even parity: the XOR over the data bits and the parity bit is 0.
  localparam logic PARITY_ODD = 1'b0;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input. Both flops reset to
// the idle-high line level.
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_Async;
      sync_q <= meta_q;
    end
  end

  assign o_Sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver for 8E1 frames (start 0, 8 data bits LSB first, even parity,
// stop 1). It emits each byte with a one-cycle strobe and parity/framing flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 3
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Rx_Active,
  output logic [2:0] o_Bit_Index
);

  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic rx;

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Rx_Serial),
    .o_Sync  (rx)
  );

  uart_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        par_q, par_d;
  logic [7:0]  shift_q, shift_d;
  logic        perr_q, perr_d;
  logic        dv_q, dv_d;
  logic [7:0]  byte_q, byte_d;
  logic        perr_out_q, perr_out_d;
  logic        ferr_q, ferr_d;
  logic        active_q, active_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    par_d      = par_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    dv_d       = 1'b0;
    byte_d     = byte_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    active_d   = active_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        idx_d = 3'd0;
        par_d = 1'b0;
        if (!rx) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = 8'd0;
          // A line that has returned high by mid-start-bit was a glitch.
          if (!rx) begin
            active_d = 1'b1;
            state_d  = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = 8'd0;
          shift_d[idx_q] = rx;
          par_d          = par_q ^ rx;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d   = 3'd0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = 8'd0;
          perr_d  = par_q ^ rx ^ PARITY_ODD;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d      = 8'd0;
          dv_d       = 1'b1;
          byte_d     = shift_q;
          perr_out_d = perr_q;
          ferr_d     = ~rx;
          active_d   = 1'b0;
          state_d    = rx ? IDLE : CLEANUP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CLEANUP: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= 3'd0;
      par_q      <= 1'b0;
      shift_q    <= 8'd0;
      perr_q     <= 1'b0;
      dv_q       <= 1'b0;
      byte_q     <= 8'd0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      dv_q       <= dv_d;
      byte_q     <= byte_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      active_q   <= active_d;
    end
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Rx_Active  = active_q;
  assign o_Bit_Index  = idx_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one receiver at CLKS_PER_BIT=3 and one at 16,
// driven by a behavioural frame generator and checked against a frame-level model.
module tb_uart_rx;

  typedef struct {
    int         cyc;
    logic [7:0] b;
    logic       pe;
    logic       fe;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx3 = 1'b1;
  logic rx16 = 1'b1;

  logic       dv3, pe3, fe3, act3;
  logic [7:0] byte3;
  logic [2:0] idx3;
  logic       dv16, pe16, fe16, act16;
  logic [7:0] byte16;
  logic [2:0] idx16;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int act16_cnt = 0;
  rec_t q3[$];
  rec_t q16[$];
  logic [2:0] idx_log[$];
  logic [2:0] prev_idx3 = 3'd0;

  uart_rx #(.CLKS_PER_BIT(3)) dut3 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx3),
    .o_Rx_DV(dv3), .o_Rx_Byte(byte3), .o_Parity_Err(pe3),
    .o_Frame_Err(fe3), .o_Rx_Active(act3), .o_Bit_Index(idx3)
  );

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx16),
    .o_Rx_DV(dv16), .o_Rx_Byte(byte16), .o_Parity_Err(pe16),
    .o_Frame_Err(fe16), .o_Rx_Active(act16), .o_Bit_Index(idx16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv3 === 1'b1) q3.push_back('{cyc, byte3, pe3, fe3});
    if (dv16 === 1'b1) q16.push_back('{cyc, byte16, pe16, fe16});
    if (act16 === 1'b1) act16_cnt <= act16_cnt + 1;
    if (idx3 !== prev_idx3) begin
      idx_log.push_back(idx3);
      prev_idx3 <= idx3;
    end
  end

  // Inputs change 1 time unit after a rising edge; each call holds for 'cycles' edges.
  task automatic drive_bit(input int which, input logic v, input int cycles);
    if (which == 0) rx3 = v; else rx16 = v;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input logic pbit,
                            input logic sbit, input int gap, output int fall_cyc);
    int cpb;
    cpb = (which == 0) ? 3 : 16;
    fall_cyc = cyc;
    drive_bit(which, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(which, b[i], cpb);
    drive_bit(which, pbit, cpb);
    drive_bit(which, sbit, cpb);
    if (gap > 0) drive_bit(which, 1'b1, gap);
  endtask

  task automatic test_reset();
    checks++; if (dv3 !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", dv3); end
    checks++; if (byte3 !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", byte3); end
    checks++; if (pe3 !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", pe3); end
    checks++; if (fe3 !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", fe3); end
    checks++; if (act3 !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", act3); end
    checks++; if (idx3 !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx3); end
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    checks++; if (q3.size() != 0) begin errors++; $display("FAIL reset_idle_dv got %0d strobes want 0", q3.size()); end
  endtask

  task automatic test_loopback();
    int base, fall;
    logic [7:0] b;
    b = 8'hA5;
    base = q3.size();
    send_frame(0, b, ^b, 1'b1, 10, fall);
    checks++;
    if (q3.size() - base != 1) begin
      errors++; $display("FAIL loop_count got %0d strobes want 1", q3.size() - base);
    end else begin
      checks++; if (q3[base].cyc != fall + 35) begin errors++; $display("FAIL loop_time got %0d want %0d", q3[base].cyc, fall + 35); end
      checks++; if (q3[base].b !== b) begin errors++; $display("FAIL loop_byte got %h want %h", q3[base].b, b); end
      checks++; if (q3[base].pe !== 1'b0) begin errors++; $display("FAIL loop_perr got %b want 0", q3[base].pe); end
      checks++; if (q3[base].fe !== 1'b0) begin errors++; $display("FAIL loop_ferr got %b want 0", q3[base].fe); end
    end
    checks++; if (byte3 !== b) begin errors++; $display("FAIL loop_hold got %h want %h", byte3, b); end
  endtask

  task automatic test_reset_midframe();
    int base;
    logic [7:0] b;
    b = 8'h5A;
    drive_bit(0, 1'b0, 3);
    for (int i = 0; i < 4; i++) drive_bit(0, b[i], 3);
    checks++; if (act3 !== 1'b1) begin errors++; $display("FAIL mid_active got %b want 1", act3); end
    rst = 1'b1;
    #1;
    checks++; if (dv3 !== 1'b0) begin errors++; $display("FAIL mid_rst_dv got %b want 0", dv3); end
    checks++; if (byte3 !== 8'h00) begin errors++; $display("FAIL mid_rst_byte got %h want 00", byte3); end
    checks++; if (pe3 !== 1'b0) begin errors++; $display("FAIL mid_rst_perr got %b want 0", pe3); end
    checks++; if (fe3 !== 1'b0) begin errors++; $display("FAIL mid_rst_ferr got %b want 0", fe3); end
    checks++; if (act3 !== 1'b0) begin errors++; $display("FAIL mid_rst_active got %b want 0", act3); end
    checks++; if (idx3 !== 3'd0) begin errors++; $display("FAIL mid_rst_idx got %0d want 0", idx3); end
    rx3 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    base = q3.size();
    repeat (100) begin @(posedge clk); #1; end
    checks++; if (q3.size() != base) begin errors++; $display("FAIL mid_no_dv got %0d strobes want 0", q3.size() - base); end
  endtask

  task automatic test_parity_err();
    int base, fall;
    base = q3.size();
    send_frame(0, 8'h07, 1'b0, 1'b1, 10, fall);
    checks++;
    if (q3.size() - base != 1) begin
      errors++; $display("FAIL par_count got %0d strobes want 1", q3.size() - base);
    end else begin
      checks++; if (q3[base].b !== 8'h07) begin errors++; $display("FAIL par_byte got %h want 07", q3[base].b); end
      checks++; if (q3[base].pe !== 1'b1) begin errors++; $display("FAIL par_perr got %b want 1", q3[base].pe); end
      checks++; if (q3[base].fe !== 1'b0) begin errors++; $display("FAIL par_ferr got %b want 0", q3[base].fe); end
    end
  endtask

  task automatic test_frame_err();
    int base, fall;
    base = q3.size();
    send_frame(0, 8'h3C, ^8'h3C, 1'b0, 0, fall);
    drive_bit(0, 1'b0, 20);
    checks++;
    if (q3.size() - base != 1) begin
      errors++; $display("FAIL frm_count got %0d strobes want 1", q3.size() - base);
    end else begin
      checks++; if (q3[base].b !== 8'h3C) begin errors++; $display("FAIL frm_byte got %h want 3c", q3[base].b); end
      checks++; if (q3[base].fe !== 1'b1) begin errors++; $display("FAIL frm_ferr got %b want 1", q3[base].fe); end
      checks++; if (q3[base].pe !== 1'b0) begin errors++; $display("FAIL frm_perr got %b want 0", q3[base].pe); end
    end
    drive_bit(0, 1'b1, 6);
    send_frame(0, 8'h11, ^8'h11, 1'b1, 10, fall);
    checks++;
    if (q3.size() - base != 2) begin
      errors++; $display("FAIL frm_next_count got %0d strobes want 2", q3.size() - base);
    end else begin
      checks++; if (q3[base+1].b !== 8'h11) begin errors++; $display("FAIL frm_next_byte got %h want 11", q3[base+1].b); end
      checks++; if (q3[base+1].fe !== 1'b0) begin errors++; $display("FAIL frm_next_ferr got %b want 0", q3[base+1].fe); end
    end
  endtask

  task automatic test_glitch();
    int base, act0, fall;
    base = q16.size();
    act0 = act16_cnt;
    drive_bit(1, 1'b0, 4);
    drive_bit(1, 1'b1, 40);
    checks++; if (q16.size() != base) begin errors++; $display("FAIL glitch_dv got %0d strobes want 0", q16.size() - base); end
    checks++; if (act16_cnt != act0) begin errors++; $display("FAIL glitch_active got %0d active cycles want 0", act16_cnt - act0); end
    send_frame(1, 8'hC3, ^8'hC3, 1'b1, 20, fall);
    checks++;
    if (q16.size() - base != 1) begin
      errors++; $display("FAIL glitch_next_count got %0d strobes want 1", q16.size() - base);
    end else begin
      checks++; if (q16[base].b !== 8'hC3) begin errors++; $display("FAIL glitch_next_byte got %h want c3", q16[base].b); end
      checks++; if (q16[base].pe !== 1'b0) begin errors++; $display("FAIL glitch_next_perr got %b want 0", q16[base].pe); end
      checks++; if (q16[base].fe !== 1'b0) begin errors++; $display("FAIL glitch_next_ferr got %b want 0", q16[base].fe); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int base, lbase, fall;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h80;
    base = q3.size();
    lbase = idx_log.size();
    for (int f = 0; f < 3; f++) send_frame(0, bytes[f], ^bytes[f], 1'b1, (f == 2) ? 10 : 0, fall);
    checks++;
    if (q3.size() - base != 3) begin
      errors++; $display("FAIL b2b_count got %0d strobes want 3", q3.size() - base);
    end else begin
      for (int f = 0; f < 3; f++) begin
        checks++; if (q3[base+f].b !== bytes[f]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", f, q3[base+f].b, bytes[f]); end
        checks++; if (q3[base+f].pe !== 1'b0 || q3[base+f].fe !== 1'b0) begin errors++; $display("FAIL b2b_err%0d got pe=%b fe=%b want 0 0", f, q3[base+f].pe, q3[base+f].fe); end
      end
    end
    checks++;
    if (idx_log.size() - lbase != 24) begin
      errors++; $display("FAIL b2b_idx_count got %0d changes want 24", idx_log.size() - lbase);
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (idx_log[lbase+i] !== 3'((i % 8) + 1)) begin
          errors++; $display("FAIL b2b_idx%0d got %0d want %0d", i, idx_log[lbase+i], 3'((i % 8) + 1));
        end
      end
    end
  endtask

  task automatic test_random();
    rec_t exp[$];
    int base, fall, gap;
    logic [7:0] b;
    logic pbit;
    base = q3.size();
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom_range(0, 255));
      pbit = ^b;
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      gap = $urandom_range(0, 5);
      exp.push_back('{0, b, (pbit != ^b), 1'b0});
      send_frame(0, b, pbit, 1'b1, gap, fall);
    end
    drive_bit(0, 1'b1, 10);
    checks++;
    if (q3.size() - base != exp.size()) begin
      errors++; $display("FAIL rnd_count got %0d strobes want %0d", q3.size() - base, exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (q3[base+i].b !== exp[i].b || q3[base+i].pe !== exp[i].pe || q3[base+i].fe !== exp[i].fe) begin
          errors++;
          $display("FAIL rnd%0d got b=%h pe=%b fe=%b want b=%h pe=%b fe=%b", i, q3[base+i].b,
                   q3[base+i].pe, q3[base+i].fe, exp[i].b, exp[i].pe, exp[i].fe);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_loopback();
    test_reset_midframe();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver paired with the `uart_tx` transmitter. It deserialises the 11-bit frame the transmitter emits: start 0, 8 data bits LSB first, even parity, stop 1. It presents each received byte with a one-cycle valid strobe and parity and framing error flags. It sits between the FPGA serial input pin and the byte consumer, running on the same clock and `CLKS_PER_BIT` as the transmitter.

## Interface
- `CLKS_PER_BIT`, default 3: clock cycles per serial bit. Legal range 3..255.
- `i_Clock`  in  1  sole clock; all logic on the rising edge.
- `i_Reset`  in  1  reset, asynchronous, active-high.
- `i_Rx_Serial`  in  1  asynchronous serial line; idles high.
- `o_Rx_DV`  out  1  one-cycle strobe; byte and error flags valid.
- `o_Rx_Byte`  out  8  last received byte; held until the next `o_Rx_DV`.
- `o_Parity_Err`  out  1  parity mismatch on the last byte; updated with `o_Rx_DV`.
- `o_Frame_Err`  out  1  stop bit sampled 0 on the last byte; updated with `o_Rx_DV`.
- `o_Rx_Active`  out  1  high from start-bit validation through the stop-bit sample.
- `o_Bit_Index`  out  3  index of the data bit currently being received.

## Operation
- **Input synchronisation:** `i_Rx_Serial` passes through a 2-flop synchroniser that resets to 1. Everything below refers to the synchronised line `rx`.
- **Half-bit point:** `H = (CLKS_PER_BIT-1)/2`, integer division.
- **Bit-period counter:** 8 bits wide.
- **States:** IDLE, START, DATA, PARITY, STOP, CLEANUP.
- **IDLE:**
  - Counter = 0, bit index = 0, running parity = 0.
  - `rx == 0` → START.
- **START:**
  - Counter increments each cycle.
  - At counter == H: if `rx == 0`, counter ← 0, `o_Rx_Active` ← 1, → DATA.
  - At counter == H with `rx == 1`: glitch; → IDLE with no output change.
- **DATA:**
  - Counter counts 0..CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1: shift register bit[index] ← `rx`, parity ← parity ^ `rx`, counter ← 0.
  - Index < 7 → index + 1. Index == 7 → index ← 0, → PARITY.
- **PARITY:** same bit-period wait; at the end, latch `parity_err = parity ^ rx`, → STOP.
- **STOP:**
  - Same bit-period wait; at the end, `o_Rx_DV` ← 1 for exactly one cycle.
  - `o_Rx_Byte`, `o_Parity_Err` and `o_Frame_Err = ~rx` are updated in that same cycle.
  - `o_Rx_Active` ← 0.
  - `rx == 1` → IDLE. `rx == 0` → CLEANUP.
- **CLEANUP:** break/framing recovery; remain until `rx == 1`, then → IDLE. A new start is not detected while in this state.
- **Undefined state encodings:** → IDLE.
- **Reset (any time, including mid-frame):**
  - State IDLE; counter, index and parity 0; synchroniser flops 1.
  - `o_Rx_DV` 0, `o_Rx_Byte` 0x00, `o_Parity_Err` 0, `o_Frame_Err` 0, `o_Rx_Active` 0, `o_Bit_Index` 0.
  - A partial frame is discarded and no `o_Rx_DV` is produced.

## Timing
- Let T be the first cycle IDLE sees `rx == 0`; this is 2 cycles after the pin falls.
- START is entered at T+1; start validation happens at T+1+H.
- Sample k (k=0..7 data, 8 parity, 9 stop) occurs at T+1+H+(k+1)·CLKS_PER_BIT.
- `o_Rx_DV` is high at T+2+H+10·CLKS_PER_BIT. For CLKS_PER_BIT=3 that is T+33.
- **Back-to-back frames:** a frame may start in the first cycle after the return to IDLE.
- **Minimum gap to the next frame:** half a bit.
- **Transmitter cleanup time:** the transmitter's CLEANUP period of one bit time is tolerated.
- **Glitch rejection:** a low pulse shorter than H+1 cycles on `rx` produces no output and no change to `o_Rx_Active`.
- **Latency:** no back-pressure; the consumer must take the byte in the `o_Rx_DV` cycle.
- **Output hold:** data outputs remain stable until the next strobe.

## Structure
- **Shared package `uart_pkg`:**
  - 3-bit state encodings, shared with `uart_tx`: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, CLEANUP=5.
  - Frame constants: DATA_BITS=8, even parity.
- **Sub-module `uart_rx_sync`:** parameter-free 2-flop synchroniser with async reset-to-1. Instantiated once.
- **Main module:** FSM, counter, shift register and output registers in `uart_rx` itself.

## Test plan
- **Reset:** assert `i_Reset` mid-DATA after 3 bits of 0x5A → all outputs at reset values immediately. Release and line idle high → no `o_Rx_DV` for 100 cycles.
- **Loopback:** `uart_tx`→`uart_rx`, CLKS_PER_BIT=3, send 0xA5 → single `o_Rx_DV` at T+33, `o_Rx_Byte`=0xA5, both error flags 0.
- **Parity error:** drive a frame for 0x07 with the parity bit forced to 0 → `o_Rx_DV` with byte 0x07, `o_Parity_Err`=1, `o_Frame_Err`=0.
- **Framing error:** frame 0x3C with the stop bit 0 and the line held low 20 more cycles → `o_Rx_DV` with `o_Frame_Err`=1. No second strobe until the line returns high and a valid new frame (0x11) arrives, which is received correctly.
- **Glitch rejection:** CLKS_PER_BIT=16, a 4-cycle low pulse on the idle line → no `o_Rx_DV`, `o_Rx_Active` stays 0. The following valid frame 0xC3 is received correctly.
- **Back-to-back:** 0x00, 0xFF, 0x80 with stop bits immediately followed by start bits → three strobes with the correct bytes, no errors, `o_Bit_Index` sequence 0..7 per frame.
